// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: serves CSR accesses, takes
// exceptions and interrupts, handles mret and drives the fetch redirect.
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic [31:0] trap_pc,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic        irq_mei,
    input  logic        instr_retire,
    input  logic        mret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305, A_MSTATUSH = 12'h310, A_MCNTINH  = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC     = 12'h341, A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343, A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80, A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00, A_TIME     = 12'hC01, A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80, A_TIMEH    = 12'hC81, A_INSTRETH = 12'hC82;
    localparam logic [11:0] A_MVENDOR  = 12'hF11, A_MARCHID  = 12'hF12, A_MIMPID   = 12'hF13;
    localparam logic [11:0] A_MHARTID  = 12'hF14, A_MCONFIG  = 12'hF15;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, mscratch_q, mscratch_d;
    logic [31:0] minh_q, minh_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [31:0] rd, wval, mip, pend, vec_pc;
    logic [63:0] cyc_inc, ret_inc;
    logic        mapped, ro, wr_req, wr_ok, irq_take, trap, mret_take;
    logic [3:0]  irq_code, trap_code;

    assign mip  = {20'b0, irq_mei, 3'b0, irq_mti, 3'b0, irq_msi, 3'b0};
    assign pend = mst_mie_q ? (mip & mie_q) : 32'b0;

    always_comb begin
        irq_code = 4'd0;
        if (pend[11])     irq_code = 4'd11;
        else if (pend[3]) irq_code = 4'd3;
        else if (pend[7]) irq_code = 4'd7;
    end

    assign irq_take  = !exc_valid && (|pend);
    assign trap      = exc_valid || irq_take;
    assign trap_code = exc_valid ? exc_code : irq_code;
    assign mret_take = mret && !trap;

    always_comb begin
        rd     = 32'b0;
        mapped = 1'b1;
        case (csr_addr)
            A_MSTATUS:                    rd = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            A_MISA:                       rd = 32'h4000_0100;
            A_MIE:                        rd = mie_q;
            A_MTVEC:                      rd = mtvec_q;
            A_MCNTINH:                    rd = minh_q;
            A_MSCRATCH:                   rd = mscratch_q;
            A_MEPC:                       rd = mepc_q;
            A_MCAUSE:                     rd = mcause_q;
            A_MTVAL:                      rd = mtval_q;
            A_MIP:                        rd = mip;
            A_MCYCLE, A_CYCLE, A_TIME:    rd = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH, A_TIMEH: rd = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:        rd = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH:      rd = minstret_q[63:32];
            A_MHARTID:                    rd = HART_ID;
            A_MSTATUSH, A_MVENDOR, A_MARCHID, A_MIMPID, A_MCONFIG: rd = 32'b0;
            default:                      mapped = 1'b0;
        endcase
    end

    // mip lives below the 2'b11 read-only region but has no storage behind it
    assign ro     = (csr_addr[11:10] == 2'b11) || (csr_addr == A_MIP);
    assign wr_req = csr_en && (csr_op != 2'b00);
    assign wr_ok  = wr_req && mapped && !ro && !trap && !mret;

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rd | csr_wdata;
            2'b11:   wval = rd & ~csr_wdata;
            default: wval = rd;
        endcase
    end

    assign cyc_inc = mcycle_q + {63'b0, ~minh_q[0]};
    assign ret_inc = minstret_q + {63'b0, instr_retire & ~exc_valid & ~minh_q[2]};

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
        minh_d     = minh_q;
        mcycle_d   = cyc_inc;
        minstret_d = ret_inc;
        if (trap) begin
            mepc_d     = trap_pc & ~32'h3;
            mcause_d   = {irq_take, 27'b0, trap_code};
            mtval_d    = exc_valid ? exc_tval : 32'b0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_take) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (wr_ok) begin
            // a write to one counter half replaces that half's increment
            case (csr_addr)
                A_MSTATUS:   begin mst_mie_d = wval[3]; mst_mpie_d = wval[7]; end
                A_MIE:       mie_d      = wval & MIE_MASK;
                A_MTVEC:     mtvec_d    = wval & ~32'h2;
                A_MCNTINH:   minh_d     = wval & 32'h5;
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d     = wval & ~32'h3;
                A_MCAUSE:    mcause_d   = wval;
                A_MTVAL:     mtval_d    = wval;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:   mcycle_d   = {wval, cyc_inc[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
                A_MINSTRETH: minstret_d = {wval, ret_inc[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= 32'b0;
            mcause_q   <= 32'b0;
            mtval_q    <= 32'b0;
            mscratch_q <= 32'b0;
            minh_q     <= 32'b0;
            mcycle_q   <= 64'b0;
            minstret_q <= 64'b0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
            minh_q     <= minh_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign vec_pc = {mtvec_q[31:2], 2'b00} +
                    ((irq_take && mtvec_q[0]) ? {26'b0, trap_code, 2'b00} : 32'b0);

    assign csr_rdata      = rst_n ? rd : 32'b0;
    assign csr_illegal    = rst_n && csr_en && (!mapped || (wr_req && ro));
    assign redirect_valid = rst_n && (trap || mret_take);
    assign redirect_pc    = !rst_n ? 32'b0 : trap ? vec_pc : mret_take ? mepc_q : 32'b0;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed and randomized check of csr_trap_unit against a behavioural CSR model.
module tb_csr_trap_unit;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0080;
    localparam logic [31:0] HART      = 32'd3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        csr_en, exc_valid, irq_msi, irq_mti, irq_mei, instr_retire, mret;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, exc_tval, trap_pc;
    logic [3:0]  exc_code;
    logic [31:0] csr_rdata, redirect_pc;
    logic        csr_illegal, redirect_valid;

    csr_trap_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval), .trap_pc(trap_pc),
        .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei), .instr_retire(instr_retire),
        .mret(mret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    bit          m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_minh;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] pool [0:26] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h310, 12'h320, 12'h340,
                                 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                 12'hB82, 12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                                 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15, 12'h7C0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = MTVEC_RST; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_minh = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic void m_read(input logic [11:0] a, output logic [31:0] v,
                                   output bit mapped, output bit ro);
        ro = (a >= 12'hC00) || (a == 12'h344);
        mapped = 1;
        v = 0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie_r;
            12'h305: v = m_mtvec;
            12'h320: v = m_minh;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = (32'(irq_mei) << 11) | (32'(irq_mti) << 7) | (32'(irq_msi) << 3);
            12'hB00, 12'hC00, 12'hC01: v = m_cyc[31:0];
            12'hB80, 12'hC80, 12'hC81: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
            12'hF14: v = HART;
            12'h310, 12'hF11, 12'hF12, 12'hF13, 12'hF15: v = 0;
            default: mapped = 0;
        endcase
    endfunction

    function automatic void m_irq(output bit hit, output logic [3:0] code);
        int pri [3] = '{11, 3, 7};
        logic [31:0] pendv;
        pendv = (32'(irq_mei) << 11) | (32'(irq_mti) << 7) | (32'(irq_msi) << 3);
        hit = 0;
        code = 0;
        for (int i = 0; i < 3; i++)
            if (!hit && m_mie && pendv[pri[i]] && m_mie_r[pri[i]]) begin
                hit = 1;
                code = 4'(pri[i]);
            end
    endfunction

    task automatic eval(input string tag);
        logic [31:0] v, e_pc;
        logic [3:0]  ic;
        bit mp, ro, hit, e_rv, e_ill;
        #1;
        m_read(csr_addr, v, mp, ro);
        m_irq(hit, ic);
        e_ill = csr_en && (!mp || (csr_op != 0 && ro));
        e_rv = 1;
        if (exc_valid)   e_pc = {m_mtvec[31:2], 2'b00};
        else if (hit)    e_pc = {m_mtvec[31:2], 2'b00} + ((m_mtvec[1:0] == 2'b01) ? 32'(ic) * 4 : 0);
        else if (mret)   e_pc = m_mepc;
        else begin e_rv = 0; e_pc = 0; end
        chk({tag, ".rdata"}, csr_rdata, v);
        chk({tag, ".illegal"}, 32'(csr_illegal), 32'(e_ill));
        chk({tag, ".rvalid"}, 32'(redirect_valid), 32'(e_rv));
        chk({tag, ".rpc"}, redirect_pc, e_pc);
    endtask

    task automatic tick();
        logic [31:0] old, nv;
        logic [63:0] cn, inn;
        logic [3:0]  ic;
        bit mp, ro, hit;
        m_read(csr_addr, old, mp, ro);
        m_irq(hit, ic);
        cn  = m_cyc + (m_minh[0] ? 64'd0 : 64'd1);
        inn = m_ins + ((instr_retire && !exc_valid && !m_minh[2]) ? 64'd1 : 64'd0);
        case (csr_op)
            2'd1:    nv = csr_wdata;
            2'd2:    nv = old | csr_wdata;
            2'd3:    nv = old & ~csr_wdata;
            default: nv = old;
        endcase
        if (exc_valid || hit) begin
            m_mepc   = trap_pc & ~32'h3;
            m_mcause = exc_valid ? {28'b0, exc_code} : (32'h8000_0000 | 32'(ic));
            m_mtval  = exc_valid ? exc_tval : 32'b0;
            m_mpie   = m_mie;
            m_mie    = 0;
        end else if (mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end else if (csr_en && csr_op != 0 && mp && !ro) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_r    = nv & 32'h888;
                12'h305: m_mtvec    = nv & ~32'h2;
                12'h320: m_minh     = nv & 32'h5;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h3;
                12'h342: m_mcause   = nv;
                12'h343: m_mtval    = nv;
                12'hB00: cn  = {m_cyc[63:32], nv};
                12'hB80: cn  = {nv, cn[31:0]};
                12'hB02: inn = {m_ins[63:32], nv};
                12'hB82: inn = {nv, inn[31:0]};
                default: ;
            endcase
        end
        m_cyc = cn;
        m_ins = inn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; exc_valid = 0; exc_code = 0;
        exc_tval = 0; trap_pc = 0; irq_msi = 0; irq_mti = 0; irq_mei = 0; instr_retire = 0; mret = 0;
    endtask

    task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d, input string tag);
        csr_en = 1; csr_op = op; csr_addr = a; csr_wdata = d;
        eval(tag);
    endtask

    initial begin
        logic [31:0] frz_i, frz_c;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        csr_en = 1; csr_addr = 12'h301; exc_valid = 1; mret = 1; csr_op = 2'b01;
        #1;
        chk("rst.rdata", csr_rdata, 32'h0);
        chk("rst.illegal", 32'(csr_illegal), 32'h0);
        chk("rst.rvalid", 32'(redirect_valid), 32'h0);
        idle();
        rst_n = 1;

        acc(2'b00, 12'h301, 0, "misa");     chk("misa", csr_rdata, 32'h4000_0100); tick();
        acc(2'b00, 12'hF14, 0, "hartid");   chk("hartid", csr_rdata, HART); tick();
        acc(2'b00, 12'h305, 0, "mtvec0");   chk("mtvec0", csr_rdata, MTVEC_RST); tick();
        acc(2'b00, 12'h300, 0, "mstatus0"); chk("mstatus0", csr_rdata, 32'h1800);
        chk("mstatus0.ill", 32'(csr_illegal), 0); tick();
        acc(2'b01, 12'h305, 32'h1003, "wr_mtvec"); tick();
        acc(2'b00, 12'h305, 0, "mtvec1");   chk("mtvec1", csr_rdata, 32'h1001); tick();
        acc(2'b01, 12'hF14, 32'h123, "wr_hartid"); chk("wr_hartid.ill", 32'(csr_illegal), 1); tick();
        acc(2'b00, 12'hF14, 0, "hartid1");  chk("hartid1", csr_rdata, HART); tick();
        acc(2'b00, 12'h7C0, 0, "unmapped"); chk("unmapped", csr_rdata, 0);
        chk("unmapped.ill", 32'(csr_illegal), 1); tick();
        acc(2'b10, 12'h300, 32'h8, "set_mie"); tick();
        acc(2'b01, 12'h304, 32'h80, "wr_mie"); tick();
        idle();

        irq_mti = 1; trap_pc = 32'h206;
        eval("mti");
        chk("mti.rvalid", 32'(redirect_valid), 1);
        chk("mti.rpc", redirect_pc, 32'h101C);
        tick(); idle();
        acc(2'b00, 12'h342, 0, "mti.mcause");  chk("mti.mcause", csr_rdata, 32'h8000_0007); tick();
        acc(2'b00, 12'h341, 0, "mti.mepc");    chk("mti.mepc", csr_rdata, 32'h204); tick();
        acc(2'b00, 12'h343, 0, "mti.mtval");   chk("mti.mtval", csr_rdata, 0); tick();
        acc(2'b00, 12'h300, 0, "mti.mstatus"); chk("mti.mstatus", csr_rdata, 32'h1880); tick();
        acc(2'b10, 12'h304, 32'h800, "set_meie"); tick();
        acc(2'b10, 12'h300, 32'h8, "set_mie2");   tick();

        exc_valid = 1; exc_code = 4'd2; exc_tval = 32'hDEAD_BEEF; trap_pc = 32'h300; irq_mei = 1;
        acc(2'b01, 12'h340, 32'h55, "exc");
        chk("exc.rpc", redirect_pc, 32'h1000);
        tick(); idle();
        acc(2'b00, 12'h342, 0, "exc.mcause");   chk("exc.mcause", csr_rdata, 2); tick();
        acc(2'b00, 12'h343, 0, "exc.mtval");    chk("exc.mtval", csr_rdata, 32'hDEAD_BEEF); tick();
        acc(2'b00, 12'h340, 0, "exc.mscratch"); chk("exc.mscratch", csr_rdata, 0); tick();

        mret = 1;
        acc(2'b00, 12'h341, 0, "mret");
        chk("mret.rvalid", 32'(redirect_valid), 1);
        chk("mret.rpc", redirect_pc, 32'h300);
        tick(); idle();
        acc(2'b00, 12'h300, 0, "mret.mstatus"); chk("mret.mstatus", csr_rdata, 32'h1888); tick();

        acc(2'b01, 12'hB80, 32'h0, "wr_cych"); tick();
        acc(2'b01, 12'hB00, 32'hFFFF_FFFF, "wr_cyc"); tick();
        acc(2'b00, 12'hB00, 0, "cyc0");  chk("cyc0", csr_rdata, 32'hFFFF_FFFF); tick();
        acc(2'b00, 12'hB80, 0, "cych1"); chk("cych1", csr_rdata, 32'h1); tick();
        acc(2'b00, 12'hB00, 0, "cyc1");  chk("cyc1", csr_rdata, 32'h1); tick();

        acc(2'b01, 12'h320, 32'hFFFF_FFFF, "inhibit"); tick();
        frz_i = m_ins[31:0];
        frz_c = m_cyc[31:0];
        for (int k = 0; k < 3; k++) begin
            instr_retire = 1;
            acc(2'b00, 12'hB02, 0, "frz.ins"); chk("frz.ins", csr_rdata, frz_i); tick();
        end
        acc(2'b00, 12'hB00, 0, "frz.cyc"); chk("frz.cyc", csr_rdata, frz_c); tick();
        acc(2'b00, 12'h320, 0, "inh.rd");  chk("inh.rd", csr_rdata, 32'h5); tick();
        acc(2'b01, 12'h320, 0, "uninhibit"); tick();
        idle();

        for (int i = 0; i < 600; i++) begin
            int pi;
            pi = $urandom_range(0, 27);
            csr_en       = $urandom_range(0, 1);
            csr_op       = 2'($urandom_range(0, 3));
            csr_addr     = (pi == 27) ? 12'($urandom) : pool[pi];
            csr_wdata    = $urandom;
            exc_valid    = ($urandom_range(0, 9) == 0);
            exc_code     = 4'($urandom);
            exc_tval     = $urandom;
            trap_pc      = $urandom;
            irq_msi      = ($urandom_range(0, 5) == 0);
            irq_mti      = ($urandom_range(0, 5) == 0);
            irq_mei      = ($urandom_range(0, 5) == 0);
            instr_retire = $urandom_range(0, 1);
            mret         = ($urandom_range(0, 7) == 0);
            if (i == 300) begin
                rst_n = 0;
                #1;
                chk("midrst.rdata", csr_rdata, 0);
                chk("midrst.rvalid", 32'(redirect_valid), 0);
                chk("midrst.illegal", 32'(csr_illegal), 0);
                model_reset();
                @(posedge clk);
                #1;
                idle();
                rst_n = 1;
                acc(2'b00, 12'h300, 0, "postrst"); chk("postrst.mstatus", csr_rdata, 32'h1800); tick();
                acc(2'b00, 12'h305, 0, "postrst"); chk("postrst.mtvec", csr_rdata, MTVEC_RST); tick();
            end else begin
                eval("rnd");
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
